// File: rtl/fifo_rd_pkg.sv
// Shared constants and helpers for the async FIFO read-side logic.
// Default widths here must match the FIFO top that feeds the unpacker.
package fifo_rd_pkg;

  localparam int unsigned FIFO_DSIZE = 32;
  localparam int unsigned FIFO_OSIZE = 8;

  // Counter width for n lanes; a single-lane word still needs one bit.
  function automatic int unsigned lane_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rd_unpack.sv
// Read-domain unpacker: pops DSIZE-bit FIFO words and streams them out as OSIZE-bit lanes.
// Define FIFO_RD_UNPACK_MSB_FIRST_EN to emit the most-significant lane of each word first.
module fifo_rd_unpack
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DSIZE = FIFO_DSIZE,
  parameter int unsigned OSIZE = FIFO_OSIZE
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  output logic [OSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  localparam int unsigned RATIO = DSIZE / OSIZE;
  localparam int unsigned LW    = lane_w(RATIO);
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  logic [DSIZE-1:0] hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [LW-1:0]    sel;
  logic             accept;
  logic             word_done;

  assign accept    = hold_valid_q && m_ready;
  assign word_done = accept && (lane_q == LAST_LANE);

  // Refill in the same cycle the last lane leaves, so words stream without bubbles.
  assign rinc = !rrst && !rempty && (!hold_valid_q || word_done);

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    lane_d       = lane_q;
    if (rinc) begin
      hold_d       = rdata;
      hold_valid_d = 1'b1;
      lane_d       = '0;
    end else if (word_done) begin
      hold_valid_d = 1'b0;
      lane_d       = '0;
    end else if (accept) begin
      lane_d       = lane_q + 1'b1;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      lane_q       <= '0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      lane_q       <= lane_d;
    end
  end

`ifdef FIFO_RD_UNPACK_MSB_FIRST_EN
  assign sel = LAST_LANE - lane_q;
`else
  assign sel = lane_q;
`endif

  assign m_data  = hold_q[int'(sel) * OSIZE +: OSIZE];
  assign m_valid = hold_valid_q;
  assign m_last  = hold_valid_q && (lane_q == LAST_LANE);

endmodule
